// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Purpose  : Shared widths, size codes and state encodings for the memory
//             port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int c_REG_BUS = 64;

    // funct3 size codes as delivered by decode
    localparam logic [2:0] c_SZ_B    = 3'b000;
    localparam logic [2:0] c_SZ_H    = 3'b001;
    localparam logic [2:0] c_SZ_W    = 3'b010;
    localparam logic [2:0] c_SZ_D    = 3'b011;
    localparam logic [2:0] c_SZ_BU   = 3'b100;
    localparam logic [2:0] c_SZ_HU   = 3'b101;
    localparam logic [2:0] c_SZ_WU   = 3'b110;
    localparam logic [2:0] c_SZ_NONE = 3'b111;

    localparam logic [1:0] c_ARB_IDLE = 2'd0;
    localparam logic [1:0] c_ARB_REQ  = 2'd1;
    localparam logic [1:0] c_ARB_WAIT = 2'd2;
    localparam logic [1:0] c_ARB_RESP = 2'd3;

    localparam logic [c_REG_BUS-1:0] c_ZERO_WORD = '0;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LS = 1'b1
    } gnt_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Memory/bus-bridge side of the shared port (request/grant/resp).
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic                  mem_req;
    logic                  mem_we;
    logic [c_REG_BUS-1:0]  mem_addr;
    logic [c_REG_BUS-1:0]  mem_wdata;
    logic [7:0]            mem_wmask;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [c_REG_BUS-1:0]  mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_lsu_align
//  Purpose  : Load/store alignment: misalignment check, store lane shift and
//             byte mask, load extraction with sign/zero extension.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter_lsu_align
    import mem_port_arbiter_pkg::*;
(
    input  wire                  i_req_we,
    input  wire [2:0]            i_req_size,
    input  wire [2:0]            i_req_off,
    output logic                 o_misaligned,
    input  wire [2:0]            i_size,
    input  wire [2:0]            i_off,
    input  wire [c_REG_BUS-1:0]  i_wdata,
    input  wire [c_REG_BUS-1:0]  i_rdata,
    output logic [c_REG_BUS-1:0] o_st_wdata,
    output logic [7:0]           o_st_wmask,
    output logic [c_REG_BUS-1:0] o_ld_data
);

    logic [5:0]           w_shamt;
    logic [7:0]           w_base_mask;
    logic [c_REG_BUS-1:0] w_ld_raw;

    // The check runs on the live request so IDLE can skip the bus cycle.
    always_comb begin
        o_misaligned = 1'b0;
        case (i_req_size[1:0])
            2'b01:   o_misaligned = i_req_off[0];
            2'b10:   o_misaligned = |i_req_off[1:0];
            2'b11:   o_misaligned = |i_req_off;
            default: o_misaligned = 1'b0;
        endcase
        if ((i_req_size == c_SZ_NONE) || (i_req_we && i_req_size[2]))
            o_misaligned = 1'b1;
    end

    assign w_shamt = {i_off, 3'b000};

    always_comb begin
        case (i_size[1:0])
            2'b00:   w_base_mask = 8'h01;
            2'b01:   w_base_mask = 8'h03;
            2'b10:   w_base_mask = 8'h0F;
            default: w_base_mask = 8'hFF;
        endcase
    end

    assign o_st_wmask = w_base_mask << i_off;
    assign o_st_wdata = i_wdata << w_shamt;
    assign w_ld_raw   = i_rdata >> w_shamt;

    always_comb begin
        case (i_size)
            c_SZ_B:  o_ld_data = {{56{w_ld_raw[7]}},  w_ld_raw[7:0]};
            c_SZ_H:  o_ld_data = {{48{w_ld_raw[15]}}, w_ld_raw[15:0]};
            c_SZ_W:  o_ld_data = {{32{w_ld_raw[31]}}, w_ld_raw[31:0]};
            c_SZ_D:  o_ld_data = w_ld_raw;
            c_SZ_BU: o_ld_data = {56'd0, w_ld_raw[7:0]};
            c_SZ_HU: o_ld_data = {48'd0, w_ld_raw[15:0]};
            c_SZ_WU: o_ld_data = {32'd0, w_ld_raw[31:0]};
            default: o_ld_data = c_ZERO_WORD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Round-robin sharing of the 64-bit memory port between fetch and
//             load/store, one outstanding transaction at a time.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  wire                  clk,
    input  wire                  rst_n,
    input  wire                  if_req,
    input  wire [c_REG_BUS-1:0]  if_addr,
    output logic                 inst_ready,
    output logic [31:0]          inst,
    input  wire                  ls_req,
    input  wire                  ls_we,
    input  wire [2:0]            ls_size,
    input  wire [c_REG_BUS-1:0]  ls_addr,
    input  wire [c_REG_BUS-1:0]  ls_wdata,
    output logic                 ls_done,
    output logic [c_REG_BUS-1:0] ls_rdata,
    output logic                 ls_err,
    mem_port_arbiter_if.master   mem
);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    gnt_e                 r_last_gnt;
    gnt_e                 r_sel;
    gnt_e                 w_pick;
    logic                 w_any;
    logic [c_REG_BUS-1:0] r_addr;
    logic [2:0]           r_size;
    logic                 r_we;
    logic [c_REG_BUS-1:0] r_wdata;
    logic [c_REG_BUS-1:0] r_rdata;
    logic                 r_err;

    logic                 w_ls_misaligned;
    logic [c_REG_BUS-1:0] w_st_wdata;
    logic [7:0]           w_st_wmask;
    logic [c_REG_BUS-1:0] w_ld_data;

    mem_port_arbiter_lsu_align u_lsu_align (
        .i_req_we     (ls_we),
        .i_req_size   (ls_size),
        .i_req_off    (ls_addr[2:0]),
        .o_misaligned (w_ls_misaligned),
        .i_size       (r_size),
        .i_off        (r_addr[2:0]),
        .i_wdata      (r_wdata),
        .i_rdata      (r_rdata),
        .o_st_wdata   (w_st_wdata),
        .o_st_wmask   (w_st_wmask),
        .o_ld_data    (w_ld_data)
    );

    // Under contention the side that did not win last time goes next.
    assign w_any  = if_req | ls_req;
    assign w_pick = (ls_req && (!if_req || (r_last_gnt == GNT_IF))) ? GNT_LS : GNT_IF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ARB_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ARB_IDLE: begin
                if (w_any)
                    w_next_state = ((w_pick == GNT_LS) && w_ls_misaligned) ? c_ARB_RESP : c_ARB_REQ;
            end
            c_ARB_REQ:  if (mem.mem_gnt)    w_next_state = c_ARB_WAIT;
            c_ARB_WAIT: if (mem.mem_rvalid) w_next_state = c_ARB_RESP;
            c_ARB_RESP: w_next_state = c_ARB_IDLE;
            default:    w_next_state = c_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= GNT_LS;
            r_sel      <= GNT_IF;
            r_addr     <= c_ZERO_WORD;
            r_size     <= c_SZ_NONE;
            r_we       <= 1'b0;
            r_wdata    <= c_ZERO_WORD;
            r_rdata    <= c_ZERO_WORD;
            r_err      <= 1'b0;
        end else begin
            if ((r_state == c_ARB_IDLE) && w_any) begin
                r_sel      <= w_pick;
                r_last_gnt <= w_pick;
                r_rdata    <= c_ZERO_WORD;
                if (w_pick == GNT_LS) begin
                    r_addr  <= ls_addr;
                    r_size  <= ls_size;
                    r_we    <= ls_we;
                    r_wdata <= ls_wdata;
                    r_err   <= w_ls_misaligned;
                end else begin
                    r_addr  <= if_addr;
                    r_size  <= c_SZ_D;
                    r_we    <= 1'b0;
                    r_wdata <= c_ZERO_WORD;
                    r_err   <= 1'b0;
                end
            end
            if ((r_state == c_ARB_WAIT) && mem.mem_rvalid)
                r_rdata <= mem.mem_rdata;
        end
    end

    // Outputs decode only from flops, so nothing combinational reaches them from inputs.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = c_ZERO_WORD;
        mem.mem_wdata = c_ZERO_WORD;
        mem.mem_wmask = 8'h00;
        inst_ready    = 1'b0;
        inst          = 32'd0;
        ls_done       = 1'b0;
        ls_rdata      = c_ZERO_WORD;
        ls_err        = 1'b0;
        case (r_state)
            c_ARB_REQ: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = r_we;
                mem.mem_addr  = {r_addr[c_REG_BUS-1:3], 3'b000};
                mem.mem_wdata = r_we ? w_st_wdata : c_ZERO_WORD;
                mem.mem_wmask = r_we ? w_st_wmask : 8'hFF;
            end
            c_ARB_RESP: begin
                if (r_sel == GNT_LS) begin
                    ls_done  = 1'b1;
                    ls_err   = r_err;
                    ls_rdata = (r_err || r_we) ? c_ZERO_WORD : w_ld_data;
                end else begin
                    inst_ready = 1'b1;
                    inst       = r_addr[2] ? r_rdata[63:32] : r_rdata[31:0];
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        inst_ready;
    logic [31:0] inst;
    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_size;
    logic [63:0] ls_addr;
    logic [63:0] ls_wdata;
    logic        ls_done;
    logic [63:0] ls_rdata;
    logic        ls_err;

    int errors = 0;
    int checks = 0;

    logic [63:0] t_addr;
    logic [63:0] t_wdata;
    logic [7:0]  t_mask;
    logic        t_we;

    mem_port_arbiter_if mem_bus ();

    mem_port_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .inst_ready (inst_ready),
        .inst       (inst),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_size    (ls_size),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_done    (ls_done),
        .ls_rdata   (ls_rdata),
        .ls_err     (ls_err),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE with a request applied; returns in the RESP cycle.
    task automatic bus_txn(input logic [63:0] rd, input int gnt_wait,
                           output logic [63:0] a, output logic [63:0] wd,
                           output logic [7:0] m, output logic w);
        tick();
        a  = mem_bus.mem_addr;
        wd = mem_bus.mem_wdata;
        m  = mem_bus.mem_wmask;
        w  = mem_bus.mem_we;
        for (int i = 0; i < gnt_wait; i++) begin
            chk("req_held", {63'd0, mem_bus.mem_req}, 64'd1);
            tick();
        end
        chk("req_on", {63'd0, mem_bus.mem_req}, 64'd1);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt    = 1'b0;
        chk("req_drop", {63'd0, mem_bus.mem_req}, 64'd0);
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = rd;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 64'd0;
    endtask

    task automatic ls_load(input string tag, input logic [2:0] sz, input logic [63:0] addr,
                           input logic [63:0] rd, input logic [63:0] exp);
        logic [63:0] a, wd;
        logic [7:0]  m;
        logic        w;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = sz; ls_addr = addr; ls_wdata = 64'd0;
        bus_txn(rd, 1, a, wd, m, w);
        chk({tag, "_addr"}, a, {addr[63:3], 3'b000});
        chk({tag, "_mask"}, {56'd0, m}, 64'hFF);
        chk({tag, "_done"}, {63'd0, ls_done}, 64'd1);
        chk({tag, "_data"}, ls_rdata, exp);
        ls_req = 1'b0;
        tick();
        chk({tag, "_pulse"}, {63'd0, ls_done}, 64'd0);
    endtask

    task automatic ls_store(input string tag, input logic [2:0] sz, input logic [63:0] addr,
                            input logic [63:0] data, input logic [63:0] exp_wd,
                            input logic [7:0] exp_m);
        logic [63:0] a, wd;
        logic [7:0]  m;
        logic        w;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = sz; ls_addr = addr; ls_wdata = data;
        bus_txn(64'hDEAD_BEEF_DEAD_BEEF, 0, a, wd, m, w);
        chk({tag, "_we"},    {63'd0, w}, 64'd1);
        chk({tag, "_wdata"}, wd, exp_wd);
        chk({tag, "_mask"},  {56'd0, m}, {56'd0, exp_m});
        chk({tag, "_done"},  {63'd0, ls_done}, 64'd1);
        chk({tag, "_rdata"}, ls_rdata, 64'd0);
        ls_req = 1'b0;
        tick();
    endtask

    task automatic ls_bad(input string tag, input logic we, input logic [2:0] sz,
                          input logic [63:0] addr);
        ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = addr; ls_wdata = 64'h1234;
        tick();
        chk({tag, "_done"},  {63'd0, ls_done}, 64'd1);
        chk({tag, "_err"},   {63'd0, ls_err}, 64'd1);
        chk({tag, "_rdata"}, ls_rdata, 64'd0);
        chk({tag, "_noreq"}, {63'd0, mem_bus.mem_req}, 64'd0);
        ls_req = 1'b0;
        tick();
        chk({tag, "_idle"},  {62'd0, ls_done, mem_bus.mem_req}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = 64'd0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 3'b111; ls_addr = 64'd0; ls_wdata = 64'd0;
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 64'd0;
        repeat (2) tick();

        chk("rst_mem_req",    {63'd0, mem_bus.mem_req}, 64'd0);
        chk("rst_mem_addr",   mem_bus.mem_addr, 64'd0);
        chk("rst_mem_wmask",  {56'd0, mem_bus.mem_wmask}, 64'd0);
        chk("rst_pulses",     {61'd0, inst_ready, ls_done, ls_err}, 64'd0);
        chk("rst_inst",       {32'd0, inst}, 64'd0);
        rst_n = 1'b1;
        tick();

        // single fetch, upper word
        if_req = 1'b1; if_addr = 64'h8000_0004;
        bus_txn(64'h1111_2222_3333_4444, 0, t_addr, t_wdata, t_mask, t_we);
        chk("fetch_addr",  t_addr, 64'h8000_0000);
        chk("fetch_we",    {63'd0, t_we}, 64'd0);
        chk("fetch_mask",  {56'd0, t_mask}, 64'hFF);
        chk("fetch_ready", {63'd0, inst_ready}, 64'd1);
        chk("fetch_inst",  {32'd0, inst}, 64'h1111_2222);
        chk("fetch_no_ls", {63'd0, ls_done}, 64'd0);
        if_req = 1'b0;
        tick();
        chk("fetch_pulse", {63'd0, inst_ready}, 64'd0);

        // contention after reset: fetch, LS, fetch
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        if_req = 1'b1; if_addr = 64'h1000;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 3'b011; ls_addr = 64'h2008;
        bus_txn(64'hAAAA_BBBB_CCCC_DDDD, 0, t_addr, t_wdata, t_mask, t_we);
        chk("cont1_addr",  t_addr, 64'h1000);
        chk("cont1_who",   {62'd0, inst_ready, ls_done}, 64'd2);
        chk("cont1_inst",  {32'd0, inst}, 64'hCCCC_DDDD);
        tick();
        bus_txn(64'h0123_4567_89AB_CDEF, 0, t_addr, t_wdata, t_mask, t_we);
        chk("cont2_addr",  t_addr, 64'h2008);
        chk("cont2_who",   {62'd0, inst_ready, ls_done}, 64'd1);
        chk("cont2_data",  ls_rdata, 64'h0123_4567_89AB_CDEF);
        chk("cont2_err",   {63'd0, ls_err}, 64'd0);
        tick();
        bus_txn(64'h7777_8888_9999_AAAA, 0, t_addr, t_wdata, t_mask, t_we);
        chk("cont3_addr",  t_addr, 64'h1000);
        chk("cont3_who",   {62'd0, inst_ready, ls_done}, 64'd2);
        chk("cont3_inst",  {32'd0, inst}, 64'h9999_AAAA);
        if_req = 1'b0; ls_req = 1'b0;
        tick();

        // loads: extraction and extension
        ls_load("lb",  3'b000, 64'h3003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        ls_load("lbu", 3'b100, 64'h3003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
        ls_load("lh",  3'b001, 64'h3002, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
        ls_load("lhu", 3'b101, 64'h3006, 64'hF00D_0000_0000_0000, 64'h0000_0000_0000_F00D);
        ls_load("lw",  3'b010, 64'h3004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        ls_load("lwu", 3'b110, 64'h3004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);

        // stores: lane shift and mask
        ls_store("sh", 3'b001, 64'h4006, 64'h0000_0000_0000_ABCD, 64'hABCD_0000_0000_0000, 8'hC0);
        ls_store("sw", 3'b010, 64'h4004, 64'h0000_0000_1122_3344, 64'h1122_3344_0000_0000, 8'hF0);
        ls_store("sb", 3'b000, 64'h4001, 64'h0000_0000_0000_005A, 64'h0000_0000_0000_5A00, 8'h02);
        ls_store("sd", 3'b011, 64'h4008, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708, 8'hFF);

        // error responses
        ls_bad("mis_lw",   1'b0, 3'b010, 64'h5002);
        ls_bad("mis_sh",   1'b1, 3'b001, 64'h5001);
        ls_bad("mis_ld",   1'b0, 3'b011, 64'h5004);
        ls_bad("bad_st",   1'b1, 3'b100, 64'h5000);
        ls_bad("bad_none", 1'b0, 3'b111, 64'h5000);

        // reset while waiting for read data
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 3'b011; ls_addr = 64'h6000;
        tick();
        chk("rw_req", {63'd0, mem_bus.mem_req}, 64'd1);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0;
        rst_n  = 1'b0;
        ls_req = 1'b0;
        #1;
        chk("rw_async_req",  {63'd0, mem_bus.mem_req}, 64'd0);
        chk("rw_async_addr", mem_bus.mem_addr, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        chk("rw_stale_pulse", {62'd0, ls_done, inst_ready}, 64'd0);
        chk("rw_stale_data",  ls_rdata, 64'd0);
        chk("rw_state",       {62'd0, dut.r_state}, {62'd0, c_ARB_IDLE});
        tick();
        chk("rw_quiet", {61'd0, ls_done, inst_ready, mem_bus.mem_req}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
